// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the writeback, secondary-writer, issue and register-file signals
// around the writeback arbiter. The slave modport is the arbiter's view; the
// master modport is the view of everything surrounding it.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 3
) ();
    logic                   pipe_we;
    logic [4:0]             pipe_dst;
    logic [63:0]            pipe_wd;
    logic [NREQ-1:0]        req_valid;
    logic [5*NREQ-1:0]      req_dst;
    logic [64*NREQ-1:0]     req_wd;
    logic [NREQ-1:0]        req_ready;
    logic                   iss_valid;
    logic [4:0]             iss_dst;
    logic                   regwrite_wb;
    logic [4:0]             dst_wb;
    logic [63:0]            regwd_wb;
    logic [31:0]            busy;
    logic                   pipe_stall;

    modport slave (
        input  pipe_we, pipe_dst, pipe_wd,
        input  req_valid, req_dst, req_wd,
        input  iss_valid, iss_dst,
        output req_ready,
        output regwrite_wb, dst_wb, regwd_wb, busy, pipe_stall
    );

    modport master (
        output pipe_we, pipe_dst, pipe_wd,
        output req_valid, req_dst, req_wd,
        output iss_valid, iss_dst,
        input  req_ready,
        input  regwrite_wb, dst_wb, regwd_wb, busy, pipe_stall
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback always owns the
// port when it writes a real register; otherwise secondary writers share it
// round-robin. A 32-bit scoreboard tracks long-latency results in flight, and
// a starvation counter asks the pipeline for a bubble when secondaries wait
// too long.
module rf_wb_arbiter #(
    parameter int NREQ       = 3,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rstn,
    rf_wb_arbiter_if.slave  bus
);
    localparam int             PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0]  LAST = PW'(NREQ - 1);
    localparam logic [3:0]     LIM  = 4'(STARVE_LIM);

    logic             pipe_eff_s;
    logic             found_s;
    logic [PW-1:0]    gidx_s;
    logic [PW-1:0]    idx_s;
    logic [NREQ-1:0]  ready_s;
    logic [4:0]       gdst_s;
    logic [63:0]      gwd_s;

    logic             regwrite_q, regwrite_d;
    logic [4:0]       dst_q, dst_d;
    logic [63:0]      regwd_q, regwd_d;
    logic [31:0]      busy_q, busy_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;

    // A pipeline write to x0 is a no-op and must not block the secondaries.
    assign pipe_eff_s = bus.pipe_we & (bus.pipe_dst != 5'd0);

    // Round-robin search: walk the requesters from the pointer, wrapping, and take the first valid one.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = '0;
        idx_s   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && !pipe_eff_s && bus.req_valid[idx_s]) begin
                found_s = 1'b1;
                gidx_s  = idx_s;
            end else begin
                found_s = found_s;
            end
            if (idx_s == LAST) begin
                idx_s = '0;
            end else begin
                idx_s = idx_s + PW'(1);
            end
        end
    end

    // One-hot ready for the winner and selection of its destination and data.
    always_comb begin
        ready_s = '0;
        gdst_s  = 5'd0;
        gwd_s   = 64'd0;
        if (found_s) begin
            ready_s[gidx_s] = 1'b1;
            gdst_s          = bus.req_dst[32'(gidx_s) * 32'd5 +: 5];
            gwd_s           = bus.req_wd[32'(gidx_s) * 32'd64 +: 64];
        end else begin
            ready_s = '0;
        end
    end

    // Next-state for the write port, pointer, starvation counter and scoreboard.
    always_comb begin
        regwrite_d = 1'b0;
        dst_d      = dst_q;
        regwd_d    = regwd_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;

        if (pipe_eff_s) begin
            regwrite_d = 1'b1;
            dst_d      = bus.pipe_dst;
            regwd_d    = bus.pipe_wd;
        end else if (found_s) begin
            // A granted write to x0 still consumes the slot but writes nothing.
            regwrite_d = (gdst_s != 5'd0);
            dst_d      = gdst_s;
            regwd_d    = gwd_s;
            ptr_d      = (gidx_s == LAST) ? '0 : gidx_s + PW'(1);
        end else begin
            regwrite_d = 1'b0;
        end

        if (found_s) begin
            cnt_d = 4'd0;
        end else if (|bus.req_valid) begin
            cnt_d = (cnt_q < LIM) ? cnt_q + 4'd1 : cnt_q;
        end else begin
            cnt_d = 4'd0;
        end

        // Clear first, then set, so a newly issued op to the same register wins.
        if (found_s && (gdst_s != 5'd0)) begin
            busy_d[gdst_s] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (bus.iss_valid && (bus.iss_dst != 5'd0)) begin
            busy_d[bus.iss_dst] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset discards any in-flight write and all pending bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regwrite_q <= 1'b0;
            dst_q      <= 5'd0;
            regwd_q    <= 64'd0;
            busy_q     <= 32'd0;
            ptr_q      <= '0;
            cnt_q      <= 4'd0;
        end else begin
            regwrite_q <= regwrite_d;
            dst_q      <= dst_d;
            regwd_q    <= regwd_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.regwrite_wb = regwrite_q;
    assign bus.dst_wb      = dst_q;
    assign bus.regwd_wb    = regwd_q;
    assign bus.busy        = busy_q;
    assign bus.pipe_stall  = (cnt_q == LIM);
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single scalar register-file write port between the in-order pipeline writeback and NREQ long-latency secondary writers (mul/div, miss-return load, vector-to-scalar move).
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW/WAW hazards against in-flight long-latency results.
- Sits between the writeback stage and the register file. Its registered outputs feed the register file, which samples them on the following negedge.

Parameters:
NREQ, 3, number of secondary writeback requesters (2..8)
STARVE_LIM, 4, consecutive cycles a pending secondary request may be denied before pipe_stall asserts (1..15)

Ports:
clk  in  1  clock, all state on posedge
rstn  in  1  reset, asynchronous, active-low
pipe_we  in  1  pipeline writeback valid (no backpressure)
pipe_dst  in  5  pipeline destination register
pipe_wd  in  64  pipeline write data
req_valid  in  NREQ  secondary request valid, bit i = requester i
req_dst  in  5*NREQ  destination, slice [5i+4:5i]
req_wd  in  64*NREQ  data, slice [64i+63:64i]
req_ready  out  NREQ  combinational grant; handshake = valid & ready
iss_valid  in  1  long-latency op issued this cycle
iss_dst  in  5  destination of issued op
regwrite_wb  out  1  registered write enable to register file
dst_wb  out  5  registered write address
regwd_wb  out  64  registered write data
busy  out  32  scoreboard, bit r = write to xr pending; bit 0 constant 0
pipe_stall  out  1  request upstream to bubble writeback (starvation relief)

Behaviour:
- Reset (rstn low, asynchronous): regwrite_wb=0, dst_wb=0, regwd_wb=0, busy=0, round-robin pointer=0, starvation counter=0, pipe_stall=0. Reset mid-operation discards all in-flight grants and pending scoreboard bits.
- pipe_eff = pipe_we & (pipe_dst!=0). The pipeline always has absolute priority.
- If pipe_eff=1: req_ready=0 for all requesters, and the next posedge loads regwrite_wb=1, dst_wb=pipe_dst, regwd_wb=pipe_wd.
- If pipe_eff=0: round-robin search among req_valid, starting at pointer p, wrapping NREQ-1 -> 0. Exactly one req_ready bit goes high, for the first valid index found. Zero bits go high if no requester is valid.
- Secondary grant to index g: next posedge loads dst_wb=req_dst[g], regwd_wb=req_wd[g], and regwrite_wb=(req_dst[g]!=0). Pointer becomes (g+1) mod NREQ.
- A secondary write to x0 is accepted, consumes the slot, and is discarded.
- No grant: regwrite_wb=0 next cycle. dst_wb and regwd_wb hold their previous values. Pointer holds.
- pipe_we=1 with pipe_dst=0 does not block secondaries.
- Latency: handshake in cycle N produces register-file outputs in cycle N+1. The register file commits at the negedge of N+1.
- Scoreboard set: iss_valid & iss_dst!=0 sets busy[iss_dst] at the next posedge.
- Scoreboard clear: a secondary handshake with req_dst[g]!=0 clears busy[req_dst[g]] at the next posedge. Pipeline writes never touch busy.
- Set and clear of the same register in one cycle: set wins and busy stays 1, because the new op supersedes the old.
- Issue to a register already busy: no change (remains 1).
- Starvation counter, 4-bit, saturating at STARVE_LIM:
  - increments when |req_valid and no secondary grant;
  - clears on any secondary grant, or when req_valid=0.
- pipe_stall = (counter==STARVE_LIM), combinational from the counter register. Upstream must present pipe_we=0 on the cycle after pipe_stall is seen. If pipe_we is still 1, the pipeline still wins and pipe_stall stays high.
- Requesters must hold req_dst and req_wd stable while req_valid=1 and not granted. The arbiter never drops a granted request.

Test Plan:
- Reset with rstn low mid-cycle -> all outputs 0 immediately (async). busy=0 even if bits were set beforehand.
- pipe_we=1, dst=5, wd=0xAA, with req_valid=3'b111 -> req_ready=0. Next cycle regwrite_wb=1, dst_wb=5, regwd_wb=0xAA.
- pipe_we=0, req_valid=3'b111 held 4 cycles -> grants in order 0,1,2,0. Each grant appears on outputs one cycle later with the matching dst/wd.
- iss_valid dst=7, then requester 1 writes dst=7 -> busy[7]=1 after issue, 0 the cycle after the handshake. In a same-cycle issue(7)+grant(7) case, busy[7] stays 1.
- Requester 2 dst=0, pipe idle -> req_ready[2]=1. Next cycle regwrite_wb=0, busy unchanged, pointer advances to 0.
- pipe_we=1 (dst=3) continuously, req_valid[0]=1, STARVE_LIM=4 -> pipe_stall=1 from the 5th cycle. Drop pipe_we the next cycle -> req_ready[0]=1, counter clears, pipe_stall=0 the following cycle.
